rd_sched: RTL and testbench

RD_SCHED -- requirements
Module: rd_sched

---
 rtl/rd_sched_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/rd_sched.sv | 106 ++++++++++
 tb/tb_rd_sched.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_sched_pkg.sv
// Shared types and constants for the reorder-bank read scheduler.
// The state register is one-hot; the bit indices name each state's flop.
package rd_sched_pkg;

    localparam int MAX_BANKS  = 8;
    localparam int S_WAIT_BIT = 0;
    localparam int S_READ_BIT = 1;

    typedef enum logic [1:0] {
        S_WAIT = 2'(1 << S_WAIT_BIT),
        S_READ = 2'(1 << S_READ_BIT)
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: returns the first request at or above base,
// wrapping modulo N and skipping any position set in the exclude mask.
module rr_pick #(
    parameter int  N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] base,
    input  logic [N-1:0]     excl,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N);

    logic [IDX_W:0] pos;

    // base < N and k < N, so one conditional subtract is a full modulo
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, base} + (IDX_W+1)'(k);
            if (pos >= N_W) begin
                pos = pos - N_W;
            end
            if (!found && req[pos[IDX_W-1:0]] && !excl[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/rd_sched.sv
// Read scheduler for a ring of reorder banks: reads each locked bank until
// it drains, pulses its release, then moves to the next bank.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_WAIT | no bank selected; waiting for the expected bank to lock
//   S_READ | reading bank rd_ptr until bank_empty[rd_ptr] is seen
module rd_sched
    import rd_sched_pkg::*;
#(
    parameter int  NUM_BANKS    = 4,
    parameter int  STRICT_ORDER = 1,
    localparam int IDX_W        = $clog2(NUM_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] bank_lock,
    input  logic [NUM_BANKS-1:0] bank_empty,
    input  logic                 rd_ready,
    output logic [NUM_BANKS-1:0] bank_rd_sel,
    output logic                 rd_en,
    output logic [IDX_W-1:0]     rd_bank_idx,
    output logic [NUM_BANKS-1:0] bank_release
);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rd_ptr_q, rd_ptr_d, ptr_inc;
    logic [NUM_BANKS-1:0] sel_q, rel_q, rel_d, cur_oh;
    logic                 in_read;
    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx, pick_base;
    logic [NUM_BANKS-1:0] pick_excl;

    assign in_read = (state_q == S_READ);
    assign cur_oh  = NUM_BANKS'(1) << rd_ptr_q;
    assign ptr_inc = (rd_ptr_q == IDX_W'(NUM_BANKS-1)) ? '0 : rd_ptr_q + IDX_W'(1);

    // In WAIT the search starts at rd_ptr; after a drain it starts one past
    // the drained bank and never picks it again.
    assign pick_base = in_read ? ptr_inc : rd_ptr_q;
    assign pick_excl = in_read ? cur_oh : '0;

    rr_pick #(
        .N (NUM_BANKS)
    ) u_pick (
        .req   (bank_lock),
        .base  (pick_base),
        .excl  (pick_excl),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        rel_d    = '0;
        case (state_q)
            S_WAIT: begin
                if (STRICT_ORDER != 0) begin
                    if (bank_lock[rd_ptr_q]) begin
                        state_d = S_READ;
                    end
                end else if (pick_found) begin
                    state_d  = S_READ;
                    rd_ptr_d = pick_idx;
                end
            end
            S_READ: begin
                if (bank_empty[rd_ptr_q]) begin
                    rel_d = cur_oh;
                    if (STRICT_ORDER != 0 && bank_lock[ptr_inc]) begin
                        rd_ptr_d = ptr_inc;
                    end else if (STRICT_ORDER == 0 && pick_found) begin
                        rd_ptr_d = pick_idx;
                    end else begin
                        state_d  = S_WAIT;
                        rd_ptr_d = ptr_inc;
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_WAIT;
            rd_ptr_q <= '0;
            sel_q    <= '0;
            rel_q    <= '0;
        end else begin
            state_q  <= state_d;
            rd_ptr_q <= rd_ptr_d;
            rel_q    <= rel_d;
            sel_q    <= (state_d == S_READ) ? (NUM_BANKS'(1) << rd_ptr_d) : '0;
        end
    end

    assign bank_rd_sel  = sel_q;
    assign bank_release = rel_q;
    assign rd_bank_idx  = rd_ptr_q;
    assign rd_en        = in_read & rd_ready & ~bank_empty[rd_ptr_q];

endmodule

// File: tb/tb_rd_sched.sv
// Bench for rd_sched: strict 4-bank, rotating 4-bank and strict 3-bank
// instances driven from per-scenario stimulus tables with a scoreboard queue.
`timescale 1ns/1ps
module tb_rd_sched;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] s4_lock, s4_empty, s4_sel, s4_rel;
    logic       s4_ready, s4_en;
    logic [1:0] s4_idx;
    logic [3:0] r4_lock, r4_empty, r4_sel, r4_rel;
    logic       r4_ready, r4_en;
    logic [1:0] r4_idx;
    logic [2:0] s3_lock, s3_empty, s3_sel, s3_rel;
    logic       s3_ready, s3_en;
    logic [1:0] s3_idx;

    rd_sched #(.NUM_BANKS(4), .STRICT_ORDER(1)) u_s4 (
        .clk(clk), .rst_n(rst_n), .bank_lock(s4_lock), .bank_empty(s4_empty),
        .rd_ready(s4_ready), .bank_rd_sel(s4_sel), .rd_en(s4_en),
        .rd_bank_idx(s4_idx), .bank_release(s4_rel)
    );

    rd_sched #(.NUM_BANKS(4), .STRICT_ORDER(0)) u_r4 (
        .clk(clk), .rst_n(rst_n), .bank_lock(r4_lock), .bank_empty(r4_empty),
        .rd_ready(r4_ready), .bank_rd_sel(r4_sel), .rd_en(r4_en),
        .rd_bank_idx(r4_idx), .bank_release(r4_rel)
    );

    rd_sched #(.NUM_BANKS(3), .STRICT_ORDER(1)) u_s3 (
        .clk(clk), .rst_n(rst_n), .bank_lock(s3_lock), .bank_empty(s3_empty),
        .rd_ready(s3_ready), .bank_rd_sel(s3_sel), .rd_en(s3_en),
        .rd_bank_idx(s3_idx), .bank_release(s3_rel)
    );

    // expected word: {bank_rd_sel[3:0], bank_release[3:0], rd_en, rd_bank_idx[1:0]}
    typedef struct packed {
        logic        tick;
        logic [3:0]  lock;
        logic [3:0]  empty;
        logic        ready;
        logic [10:0] want;
    } vec_t;

    logic [10:0] sb [$];
    int total = 0;
    int bad   = 0;

    function automatic vec_t mk(input logic tick, input logic [3:0] lock,
                                input logic [3:0] empty, input logic ready,
                                input logic [3:0] sel, input logic [3:0] rel,
                                input logic en, input logic [1:0] idx);
        vec_t v;
        v.tick  = tick;
        v.lock  = lock;
        v.empty = empty;
        v.ready = ready;
        v.want  = {sel, rel, en, idx};
        return v;
    endfunction

    task automatic drive(input int d, input vec_t v);
        case (d)
            0: begin s4_lock = v.lock; s4_empty = v.empty; s4_ready = v.ready; end
            1: begin r4_lock = v.lock; r4_empty = v.empty; r4_ready = v.ready; end
            default: begin
                s3_lock = v.lock[2:0]; s3_empty = v.empty[2:0]; s3_ready = v.ready;
            end
        endcase
    endtask

    function automatic logic [10:0] obs(input int d);
        case (d)
            0:       return {s4_sel, s4_rel, s4_en, s4_idx};
            1:       return {r4_sel, r4_rel, r4_en, r4_idx};
            default: return {1'b0, s3_sel, 1'b0, s3_rel, s3_en, s3_idx};
        endcase
    endfunction

    task automatic test_reset();
        logic [10:0] want;
        vec_t v;
        v = mk(1, 4'b1111, 4'b0000, 1, 4'b0, 4'b0, 0, 2'd0);
        for (int d = 0; d < 3; d++) drive(d, v);
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 3; d++) sb.push_back(11'd0);
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                want = sb.pop_front();
                total++;
                if (obs(d) !== want) begin
                    bad++;
                    $display("FAIL reset dut%0d cyc%0d: got %b want %b", d, r, obs(d), want);
                end
            end
        end
        v = mk(1, 4'b0000, 4'b0000, 1, 4'b0, 4'b0, 0, 2'd0);
        for (int d = 0; d < 3; d++) drive(d, v);
        #4 rst_n = 1'b1;
    endtask

    task automatic test_first_read();
        vec_t v [$];
        logic [10:0] want;
        v.push_back(mk(1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 1, 2'd0));
        foreach (v[i]) begin
            drive(0, v[i]);
            sb.push_back(v[i].want);
            if (v[i].tick) begin @(posedge clk); #1; end else #1;
            want = sb.pop_front();
            total++;
            if (obs(0) !== want) begin
                bad++;
                $display("FAIL first_read[%0d]: got %b want %b", i, obs(0), want);
            end
        end
    endtask

    task automatic test_ready_stall();
        vec_t v [$];
        logic [10:0] want;
        v.push_back(mk(1, 4'b1101, 4'b1110, 0, 4'b0001, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b0011, 4'b0110, 0, 4'b0001, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b1001, 4'b0000, 0, 4'b0001, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b0101, 4'b1010, 0, 4'b0001, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b1111, 4'b0010, 0, 4'b0001, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 1, 2'd0));
        v.push_back(mk(0, 4'b0011, 4'b0001, 1, 4'b0001, 4'b0000, 0, 2'd0));
        foreach (v[i]) begin
            drive(0, v[i]);
            sb.push_back(v[i].want);
            if (v[i].tick) begin @(posedge clk); #1; end else #1;
            want = sb.pop_front();
            total++;
            if (obs(0) !== want) begin
                bad++;
                $display("FAIL ready_stall[%0d]: got %b want %b", i, obs(0), want);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v [$];
        logic [10:0] want;
        v.push_back(mk(1, 4'b0011, 4'b0001, 1, 4'b0010, 4'b0001, 1, 2'd1));
        v.push_back(mk(1, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 1, 2'd1));
        v.push_back(mk(1, 4'b0110, 4'b0010, 1, 4'b0100, 4'b0010, 1, 2'd2));
        v.push_back(mk(1, 4'b1100, 4'b0100, 1, 4'b1000, 4'b0100, 1, 2'd3));
        foreach (v[i]) begin
            drive(0, v[i]);
            sb.push_back(v[i].want);
            if (v[i].tick) begin @(posedge clk); #1; end else #1;
            want = sb.pop_front();
            total++;
            if (obs(0) !== want) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, obs(0), want);
            end
        end
    endtask

    task automatic test_strict_wait();
        vec_t v [$];
        logic [10:0] want;
        v.push_back(mk(1, 4'b0100, 4'b1000, 1, 4'b0000, 4'b1000, 0, 2'd0));
        v.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b0100, 4'b0000, 1, 4'b0000, 4'b0000, 0, 2'd0));
        v.push_back(mk(1, 4'b0101, 4'b0000, 1, 4'b0001, 4'b0000, 1, 2'd0));
        foreach (v[i]) begin
            drive(0, v[i]);
            sb.push_back(v[i].want);
            if (v[i].tick) begin @(posedge clk); #1; end else #1;
            want = sb.pop_front();
            total++;
            if (obs(0) !== want) begin
                bad++;
                $display("FAIL strict_wait[%0d]: got %b want %b", i, obs(0), want);
            end
        end
    endtask

    task automatic test_rotate();
        vec_t v [$];
        logic [10:0] want;
        v.push_back(mk(1, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 1, 2'd1));
        v.push_back(mk(1, 4'b1001, 4'b0010, 1, 4'b1000, 4'b0010, 1, 2'd3));
        v.push_back(mk(1, 4'b1001, 4'b1000, 1, 4'b0001, 4'b1000, 1, 2'd0));
        v.push_back(mk(1, 4'b0000, 4'b0001, 1, 4'b0000, 4'b0001, 0, 2'd1));
        v.push_back(mk(1, 4'b0101, 4'b0000, 1, 4'b0100, 4'b0000, 1, 2'd2));
        foreach (v[i]) begin
            drive(1, v[i]);
            sb.push_back(v[i].want);
            if (v[i].tick) begin @(posedge clk); #1; end else #1;
            want = sb.pop_front();
            total++;
            if (obs(1) !== want) begin
                bad++;
                $display("FAIL rotate[%0d]: got %b want %b", i, obs(1), want);
            end
        end
    endtask

    task automatic test_wrap3();
        vec_t v [$];
        logic [10:0] want;
        v.push_back(mk(1, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 1, 2'd0));
        v.push_back(mk(1, 4'b0011, 4'b0001, 1, 4'b0010, 4'b0001, 1, 2'd1));
        v.push_back(mk(1, 4'b0110, 4'b0010, 1, 4'b0100, 4'b0010, 1, 2'd2));
        v.push_back(mk(1, 4'b0101, 4'b0100, 1, 4'b0001, 4'b0100, 1, 2'd0));
        v.push_back(mk(1, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0000, 1, 2'd0));
        foreach (v[i]) begin
            drive(2, v[i]);
            sb.push_back(v[i].want);
            if (v[i].tick) begin @(posedge clk); #1; end else #1;
            want = sb.pop_front();
            total++;
            if (obs(2) !== want) begin
                bad++;
                $display("FAIL wrap3[%0d]: got %b want %b", i, obs(2), want);
            end
        end
    endtask

    // all three instances are mid-READ with their bank about to drain
    task automatic test_reset_mid_read();
        logic [10:0] want;
        drive(0, mk(1, 4'b0101, 4'b0001, 1, 4'b0, 4'b0, 0, 2'd0));
        drive(1, mk(1, 4'b0101, 4'b0100, 1, 4'b0, 4'b0, 0, 2'd0));
        drive(2, mk(1, 4'b0001, 4'b0001, 1, 4'b0, 4'b0, 0, 2'd0));
        rst_n = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 3; d++) sb.push_back(11'd0);
            if (r == 0) #1;
            else begin @(posedge clk); #1; end
            for (int d = 0; d < 3; d++) begin
                want = sb.pop_front();
                total++;
                if (obs(d) !== want) begin
                    bad++;
                    $display("FAIL mid_reset dut%0d step%0d: got %b want %b", d, r, obs(d), want);
                end
            end
        end
        #4 rst_n = 1'b1;
        sb.push_back({4'b0001, 4'b0000, 1'b0, 2'd0});
        sb.push_back({4'b0001, 4'b0000, 1'b1, 2'd0});
        sb.push_back({4'b0001, 4'b0000, 1'b0, 2'd0});
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            want = sb.pop_front();
            total++;
            if (obs(d) !== want) begin
                bad++;
                $display("FAIL post_reset dut%0d: got %b want %b", d, obs(d), want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_ready_stall();
        test_back_to_back();
        test_strict_wait();
        test_rotate();
        test_wrap3();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
